conbus_timeout: RTL
===================

Name: conbus_timeout

Overview:
- Wishbone bus watchdog inserted on one slave port of the conbus interconnect, between the interconnect's slave-side outputs and the physical peripheral.
- Passes transfers through unchanged.
- If the peripheral fails to ack within TIMEOUT cycles, it terminates the cycle toward the peripheral and returns ERR_DATA with a synthetic ack, so the granted master never hangs the shared bus.
- Records the failing access for software diagnosis.

Parameters:
- TIMEOUT, 16: cycles of cyc&stb without ack before abort; legal range 2..255.
- ERR_DATA, 32'hdeadbeef: read data returned on a timed-out access.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  reset; asynchronous assert, active-high
- m_dat_i  in  32  write data from interconnect
- m_dat_o  out  32  read data to interconnect
- m_adr_i  in  32  address
- m_cti_i  in  3  cycle type
- m_sel_i  in  4  byte select
- m_we_i  in  1  write enable
- m_cyc_i  in  1  cycle
- m_stb_i  in  1  strobe
- m_ack_o  out  1  ack to interconnect
- s_dat_i  in  32  read data from peripheral
- s_dat_o  out  32  write data to peripheral
- s_adr_o  out  32  address to peripheral
- s_cti_o  out  3  cycle type to peripheral
- s_sel_o  out  4  byte select to peripheral
- s_we_o  out  1  write enable to peripheral
- s_cyc_o  out  1  cycle to peripheral
- s_stb_o  out  1  strobe to peripheral
- s_ack_i  in  1  ack from peripheral
- err_o  out  1  one-cycle pulse on each timeout
- err_sticky_o  out  1  set by timeout, cleared by clr_i
- err_count_o  out  16  saturating timeout count
- err_adr_o  out  32  address of the most recent timed-out access
- err_we_o  out  1  we of the most recent timed-out access
- clr_i  in  1  synchronous clear of sticky flag and count

Behaviour:
- Clock and reset: single clock sys_clk; sys_rst is asynchronous, active-high. On reset:
  - state=IDLE, cnt=0, err_o=0, err_sticky_o=0, err_count_o=0, err_adr_o=0, err_we_o=0.
  - s_cyc_o/s_stb_o are forced 0 while sys_rst is high.
- Pass-through (combinational, zero latency) in IDLE and WAIT:
  - s_adr/cti/sel/we/dat_o = m_* inputs.
  - s_cyc_o = m_cyc_i, s_stb_o = m_stb_i.
  - m_ack_o = s_ack_i & m_cyc_i & m_stb_i.
  - m_dat_o = s_dat_i.
- State IDLE:
  - m_cyc_i&m_stb_i&!s_ack_i -> WAIT, cnt<=1.
  - Same-cycle ack stays IDLE (combinational slave).
- State WAIT:
  - s_ack_i -> cnt<=0, then IDLE.
  - m_stb_i or m_cyc_i deasserted (master withdrew) -> IDLE, cnt<=0, no error.
  - cnt==TIMEOUT-1 with no ack -> TOUT.
  - Otherwise cnt<=cnt+1.
  - Net effect: strobe first seen at cycle 0 with no ack through cycle TIMEOUT-1 gives the synthetic ack at cycle TIMEOUT.
- State TOUT (exactly 1 cycle):
  - s_cyc_o=0, s_stb_o=0.
  - m_ack_o=1, m_dat_o=ERR_DATA.
  - err_o=1; err_adr_o<=m_adr_i, err_we_o<=m_we_i; err_sticky_o<=1; err_count_o<=sat(count+1).
  - Any s_ack_i this cycle is masked.
  - Next state RECOVER.
- State RECOVER (exactly 1 cycle):
  - s_cyc_o=0, s_stb_o=0, m_ack_o=0; s_ack_i masked.
  - Guarantees the peripheral sees the cycle terminate.
  - Next state IDLE. A master still strobing (burst, cti!=3'b111) restarts a fresh count from IDLE.
- Counter widths:
  - cnt is 8 bits.
  - err_count_o saturates at 16'hffff and does not wrap.
- Simultaneous events:
  - clr_i and timeout in the same cycle: timeout wins, so sticky=1 and count=1.
  - s_ack_i arriving on the TIMEOUT-1 cycle counts as success; no error.
- Reset asserted mid-WAIT or mid-TOUT: immediate return to IDLE with all outputs at reset values; the pending access gets no ack.

Decomposition:
- Shared conbus package holds:
  - state encoding constants (IDLE=2'd0, WAIT=2'd1, TOUT=2'd2, RECOVER=2'd3);
  - default ERR_DATA;
  - the Wishbone field widths (adr 32, cti 3, sel 4, dat 32).
- No sub-module required. The error-capture and saturating-counter logic may optionally be split out as conbus_timeout_log.

Test Plan:
- Peripheral acks at cycle 3 of a read, s_dat_i=32'h12345678 -> m_ack_o at cycle 3, m_dat_o=32'h12345678, err_o never asserted, err_count_o=0.
- Peripheral never acks a read at 32'h40000010, TIMEOUT=16 -> m_ack_o=1 and m_dat_o=32'hdeadbeef at cycle 16; s_cyc_o=0 at cycles 16–17; err_adr_o=32'h40000010; err_sticky_o=1; err_count_o=1.
- Ack arrives exactly at cycle 15 -> normal ack, no error; ack at cycle 16 -> masked, synthetic ack, error logged.
- Master drops stb at cycle 8 with no ack -> no error; state IDLE; a subsequent access is counted from 0.
- clr_i coincident with a timeout -> err_sticky_o=1, err_count_o=1; clr_i alone afterwards -> sticky=0, count=0.
- Force 70000 timeouts -> err_count_o holds 16'hffff. Assert sys_rst mid-WAIT -> outputs return to reset values asynchronously, with no ack.

Source files
------------

// File: rtl/conbus_timeout_pkg.sv
// conbus timeout watchdog: state encoding, Wishbone field widths
// and the saturating error-count helper.
package conbus_timeout_pkg;

    localparam int ADR_W  = 32;
    localparam int CTI_W  = 3;
    localparam int SEL_W  = 4;
    localparam int DAT_W  = 32;
    localparam int CNT_W  = 8;
    localparam int ERRC_W = 16;

    localparam logic [DAT_W-1:0] ERR_DATA_DEF = 32'hdeadbeef;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        TOUT    = 2'd2,
        RECOVER = 2'd3
    } state_e;

    function automatic logic [ERRC_W-1:0] sat_inc(
        input logic [ERRC_W-1:0] v
    );
        return (v == '1) ? v : v + ERRC_W'(1);
    endfunction

endpackage

// File: rtl/conbus_timeout_if.sv
// Wishbone bundle around the watchdog: interconnect side (m_*)
// and peripheral side (s_*), named from the watchdog's viewpoint.
interface conbus_timeout_if import conbus_timeout_pkg::*; ();

    logic [DAT_W-1:0] m_dat_i;
    logic [DAT_W-1:0] m_dat_o;
    logic [ADR_W-1:0] m_adr_i;
    logic [CTI_W-1:0] m_cti_i;
    logic [SEL_W-1:0] m_sel_i;
    logic             m_we_i;
    logic             m_cyc_i;
    logic             m_stb_i;
    logic             m_ack_o;

    logic [DAT_W-1:0] s_dat_i;
    logic [DAT_W-1:0] s_dat_o;
    logic [ADR_W-1:0] s_adr_o;
    logic [CTI_W-1:0] s_cti_o;
    logic [SEL_W-1:0] s_sel_o;
    logic             s_we_o;
    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_ack_i;

    modport slave (
        input  m_dat_i, m_adr_i, m_cti_i, m_sel_i,
        input  m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o,
        output s_dat_o, s_adr_o, s_cti_o, s_sel_o,
        output s_we_o, s_cyc_o, s_stb_o
    );

    modport master (
        output m_dat_i, m_adr_i, m_cti_i, m_sel_i,
        output m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o,
        input  s_dat_o, s_adr_o, s_cti_o, s_sel_o,
        input  s_we_o, s_cyc_o, s_stb_o
    );

endinterface

// File: rtl/conbus_timeout.sv
// Wishbone watchdog: passes transfers through, aborts a stalled one
// with a synthetic ack carrying ERR_DATA, and logs the failing access.
module conbus_timeout import conbus_timeout_pkg::*; #(
    parameter int               TIMEOUT  = 16,
    parameter logic [DAT_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    conbus_timeout_if.slave   bus,
    input  logic              clr_i,
    output logic              err_o,
    output logic              err_sticky_o,
    output logic [ERRC_W-1:0] err_count_o,
    output logic [ADR_W-1:0]  err_adr_o,
    output logic              err_we_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q;
    logic [ERRC_W-1:0] ecnt_q;
    logic [ADR_W-1:0]  eadr_q;
    logic              ewe_q;
    logic              req;
    logic              pass;

    assign req = bus.m_cyc_i & bus.m_stb_i;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req && !bus.s_ack_i) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (!req || bus.s_ack_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = TOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TOUT: begin
                state_d = RECOVER;
            end
            RECOVER: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.s_dat_o = bus.m_dat_i;
    assign bus.s_adr_o = bus.m_adr_i;
    assign bus.s_cti_o = bus.m_cti_i;
    assign bus.s_sel_o = bus.m_sel_i;
    assign bus.s_we_o  = bus.m_we_i;

    // TOUT and RECOVER hide the peripheral and mask its late ack.
    always_comb begin
        pass        = ((state_q == IDLE) || (state_q == WAIT)) && !sys_rst;
        bus.s_cyc_o = bus.m_cyc_i & pass;
        bus.s_stb_o = bus.m_stb_i & pass;
        bus.m_ack_o = req & bus.s_ack_i & pass;
        bus.m_dat_o = bus.s_dat_i;
        err_o       = 1'b0;
        if (state_q == TOUT) begin
            bus.m_ack_o = 1'b1;
            bus.m_dat_o = ERR_DATA;
            err_o       = 1'b1;
        end
    end

    // A timeout beats a coincident clear: the new error must not be lost.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sticky_q <= 1'b0;
            ecnt_q   <= '0;
            eadr_q   <= '0;
            ewe_q    <= 1'b0;
        end else if (state_q == TOUT) begin
            sticky_q <= 1'b1;
            ecnt_q   <= clr_i ? ERRC_W'(1) : sat_inc(ecnt_q);
            eadr_q   <= bus.m_adr_i;
            ewe_q    <= bus.m_we_i;
        end else if (clr_i) begin
            sticky_q <= 1'b0;
            ecnt_q   <= '0;
        end
    end

    assign err_sticky_o = sticky_q;
    assign err_count_o  = ecnt_q;
    assign err_adr_o    = eadr_q;
    assign err_we_o     = ewe_q;

endmodule
